sc_random_arbiter: RTL

Round-robin controller that shares one free-running random generator among four requesters. The generator shifts every clock, so consecutive clock samples are strongly correlated. This block samples the generator value only when a requester asks, and enforces a minimum number of shift cycles between any two delivered samples. It also detects the all-zero lock-up of the generator and requests a reseed from top level. It sits between the generator output bus and the game/logic blocks consuming random values.

---
 rtl/sc_random_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sc_random_arbiter.sv
// sc_random_arbiter
// Shares one free-running random generator among four requesters. A sample is
// taken only when a requester asks, grants are spaced by at least RANDOM_GAP
// generator shifts, and an all-zero generator value triggers a reseed request.
module sc_random_arbiter #(
   parameter int RANDOM_DATAWIDTH = 8,
   parameter int RANDOM_GAP       = 8
) (
   input  logic                        SC_RANDOM_CLOCK_50,
   input  logic                        SC_RANDOM_RESET_InHigh,
   input  logic [RANDOM_DATAWIDTH-1:0] rnd_in,
   input  logic [3:0]                  req,
   output logic [3:0]                  ack,
   output logic [RANDOM_DATAWIDTH-1:0] data,
   output logic                        reseed,
   output logic                        busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLDOFF = 2'd1,
      ST_STUCK   = 2'd2
   } state_t;

   // Hold-off reload value: the grant edge itself counts as the first shift.
   localparam logic [7:0] GAP_RELOAD  = 8'(RANDOM_GAP - 1);
   localparam bit         USE_HOLDOFF = (RANDOM_GAP > 1);

   state_t                      state_q, state_d;
   logic [1:0]                  ptr_q, ptr_d;
   logic [7:0]                  cnt_q, cnt_d;
   logic [3:0]                  stuckcnt_q, stuckcnt_d;
   logic [3:0]                  mask_q, mask_d;
   logic [3:0]                  ack_q, ack_d;
   logic [RANDOM_DATAWIDTH-1:0] data_q, data_d;
   logic                        reseed_q, reseed_d;
   logic                        busy_q;

   logic [3:0]                  eff_req_s;
   logic [2:0]                  pick_s;
   logic                        rnd_zero_s;

   // Round-robin search: returns {found, index}, nearest index after 'last' wins.
   // Scanning from the farthest candidate to the nearest lets the nearest overwrite.
   function automatic logic [2:0] rr_pick(input logic [3:0] eff, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (eff[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign eff_req_s  = req & ~mask_q;
   assign pick_s     = rr_pick(eff_req_s, ptr_q);
   assign rnd_zero_s = (rnd_in == {RANDOM_DATAWIDTH{1'b0}});

   // Next-state logic: zero lock-up check overrides every state, then the FSM.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      stuckcnt_d = stuckcnt_q;
      mask_d     = 4'b0000;
      ack_d      = 4'b0000;
      data_d     = data_q;
      reseed_d   = 1'b0;
      if (rnd_zero_s) begin
         if (state_q == ST_STUCK) begin
            stuckcnt_d = stuckcnt_q + 4'd1;
            reseed_d   = (stuckcnt_q == 4'd15);
         end else begin
            state_d    = ST_STUCK;
            stuckcnt_d = 4'd0;
            reseed_d   = 1'b1;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_s[2]) begin
                  ack_d  = 4'b0001 << pick_s[1:0];
                  mask_d = 4'b0001 << pick_s[1:0];
                  data_d = rnd_in;
                  ptr_d  = pick_s[1:0];
                  if (USE_HOLDOFF) begin
                     cnt_d   = GAP_RELOAD;
                     state_d = ST_HOLDOFF;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_HOLDOFF: begin
               // cnt of zero cannot occur, but exiting there keeps the FSM from stalling.
               if (cnt_q <= 8'd1) begin
                  cnt_d   = 8'd0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q - 8'd1;
                  state_d = ST_HOLDOFF;
               end
            end
            ST_STUCK: begin
               stuckcnt_d = stuckcnt_q + 4'd1;
               cnt_d      = 8'd0;
               state_d    = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously by the system reset.
   always_ff @(posedge SC_RANDOM_CLOCK_50 or posedge SC_RANDOM_RESET_InHigh) begin
      if (SC_RANDOM_RESET_InHigh) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 2'd3;
         cnt_q      <= 8'd0;
         stuckcnt_q <= 4'd0;
         mask_q     <= 4'b0000;
         ack_q      <= 4'b0000;
         data_q     <= {RANDOM_DATAWIDTH{1'b0}};
         reseed_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         stuckcnt_q <= stuckcnt_d;
         mask_q     <= mask_d;
         ack_q      <= ack_d;
         data_q     <= data_d;
         reseed_q   <= reseed_d;
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign ack    = ack_q;
   assign data   = data_q;
   assign reseed = reseed_q;
   assign busy   = busy_q;

endmodule
